weight_flip_writer: RTL and testbench
=====================================

// Module: weight_flip_writer
// PURPOSE
//  Downstream consumer of the per-weight accumulator bank's one-cycle trigger pulses.
//  Each trigger toggles one binary weight stored in packed words of the weight RAM.
//  Pending triggers are kept as a bitmap. All pending bits that fall in one RAM word
//  are applied together by a single read-modify-write.
//  Shares the weight RAM with the forward pass through a request/grant lock.
// PARAMETERS
//  N_W      256  number of binary weights (= trigger vector width); must be a multiple of WORD_W
//  WORD_W   32   bits per weight RAM word
//  CNT_W    16   width of the applied-flip counter
//  (local) N_WORDS = N_W/WORD_W; ADDR_W = max(1,$clog2(N_WORDS))
// PORTS
//  clk_in        in   1        clock
//  rst_in        in   1        asynchronous, active-high reset
//  trig_in       in   N_W      trigger pulses; bit i = toggle weight i
//  clr_ovf_in    in   1        clears ovf_out
//  mem_req_out   out  1        RAM access request; held high from REQ through WRITE
//  mem_gnt_in    in   1        arbiter grant; once given, held until mem_req_out drops
//  mem_addr_out  out  ADDR_W   word address; valid while mem_req_out is high
//  mem_rd_en_out out  1        read strobe; RAM read latency is 1 cycle
//  mem_rd_data_in in  WORD_W   read data, valid in the cycle after mem_rd_en_out
//  mem_wr_en_out out  1        write strobe
//  mem_wr_data_out out WORD_W  write data
//  busy_out      out  1        high when state != IDLE or pending != 0
//  ovf_out       out  1        sticky flag: a trigger hit a bit that was already pending
//  flips_out     out  CNT_W    total weights toggled; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (asynchronous):
//   - pending=0, state=IDLE; every output is 0.
//   - An in-flight RMW is abandoned: mem_wr_en_out drops immediately and no partial write occurs.
//  Pending bitmap, updated every edge:
//   - pending <= (pending & ~clr) | trig_in, where clr = latched mask bits in the IDLE->REQ cycle, else 0.
//   - Same-edge clear and set of a bit leaves it set; it is serviced by a later RMW.
//   - If trig_in[i] & pending[i] & ~clr[i], the trigger is dropped and ovf_out <= 1.
//   - ovf_out clears only on clr_ovf_in; if set and clear coincide, set wins.
//  FSM, states IDLE, REQ, WAIT, WRITE:
//   - IDLE:  if pending != 0:
//            w = word holding the lowest set pending bit (priority encoder);
//            latch addr <= w, mask <= pending[w*WORD_W +: WORD_W];
//            clear those bits; go to REQ.
//   - REQ:   mem_req_out=1. When mem_gnt_in=1: mem_rd_en_out=1 in the same cycle,
//            then go to WAIT. Otherwise stay in REQ indefinitely.
//   - WAIT:  mem_req_out=1; register mem_rd_data_in; go to WRITE.
//   - WRITE: mem_req_out=1, mem_wr_en_out=1, mem_wr_data_out = rd_q ^ mask;
//            flips_out += popcount(mask); go to IDLE.
//   - mem_rd_en_out, mem_wr_en_out and mem_wr_data_out are 0 outside the cases above.
//  Latency and ordering:
//   - Trigger at cycle 0 -> REQ at cycle 2 -> with immediate grant, write at cycle 4.
//   - Minimum 4 cycles per RMW. Words are serviced lowest-index-first, with no fairness.
//  Triggers on bits of the word in flight (after the latch) stay pending and get a later RMW;
//  no ovf is raised.
// STRUCTURE
//  - Package bitnet_pkg: typedef enum flip_state_t {IDLE,REQ,WAIT,WRITE};
//    default WORD_W, N_W, CNT_W constants.
//  - Sub-module lowest_set_idx #(W): combinational priority encoder giving the index
//    of the lowest set bit plus a valid flag. The word index is that result divided by WORD_W.
//  - Popcount is an inline function in the package.
// TESTING
//  1. trig_in bit 5 pulsed, gnt tied 1, word0=0 -> write addr0 data 0x00000020 at cycle 4;
//     flips_out=1; busy_out low at cycle 5.
//  2. Bits 3 and 7 in one pulse, word0=0x000000FF -> single RMW: write 0x00000077, flips_out=2.
//  3. Bits 40 and 2 pulsed, all words 0 -> word0 is written first (0x4), then word1
//     (0x100); 2 RMWs, flips_out=2.
//  4. Bit 9 pulsed twice while it is still pending (gnt held 0) -> ovf_out=1, only one
//     toggle applied; clr_ovf_in clears the flag.
//  5. Bit 1 pulsed in the WAIT cycle of an RMW on word0 -> a second RMW on word0 follows
//     and bit 1 ends toggled; ovf_out stays 0.
//  6. rst_in asserted during WAIT -> all outputs 0 asynchronously, no write occurs,
//     and after release the RAM contents are unchanged.

Source files
------------

// File: rtl/bitnet_pkg.sv
// Shared types and defaults for the binary-weight update path.
package bitnet_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} flip_state_t;

  localparam int N_W_DEF    = 256;
  localparam int WORD_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int POP_W      = 64;

  // Narrower words are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [POP_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < POP_W; i++) begin
      c += {31'b0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Combinational priority encoder: index of the lowest set bit, plus a valid flag.
module lowest_set_idx #(
  parameter int W = 256,
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     vec_in,
  output logic [IDX_W-1:0] idx_out,
  output logic             valid_out
);

  always_comb begin
    idx_out   = '0;
    valid_out = 1'b0;
    // Scan downward so the last hit is the lowest index.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_in[i]) begin
        idx_out   = IDX_W'(i);
        valid_out = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_flip_writer.sv
// Collects weight-toggle triggers into a pending bitmap and applies them to the
// packed weight RAM one word at a time with a locked read-modify-write.
module weight_flip_writer
  import bitnet_pkg::*;
#(
  parameter int N_W    = N_W_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  localparam int N_WORDS = N_W / WORD_W,
  localparam int ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [N_W-1:0]    trig_in,
  input  logic              clr_ovf_in,
  output logic              mem_req_out,
  input  logic              mem_gnt_in,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_rd_en_out,
  input  logic [WORD_W-1:0] mem_rd_data_in,
  output logic              mem_wr_en_out,
  output logic [WORD_W-1:0] mem_wr_data_out,
  output logic              busy_out,
  output logic              ovf_out,
  output logic [CNT_W-1:0]  flips_out
);

  localparam int IDX_W = (N_W > 1) ? $clog2(N_W) : 1;

  flip_state_t       state_reg, state_next;
  logic [N_W-1:0]    pending_reg, pending_next, clr_vec, hit_vec;
  logic [ADDR_W-1:0] addr_reg, word_idx;
  logic [WORD_W-1:0] mask_reg, rd_q_reg, word_bits;
  logic [CNT_W-1:0]  flips_reg, pop_cnt;
  logic              ovf_reg;
  logic [IDX_W-1:0]  low_idx;
  logic              low_valid, take;

  lowest_set_idx #(.W(N_W)) u_lowest (
    .vec_in   (pending_reg),
    .idx_out  (low_idx),
    .valid_out(low_valid)
  );

  assign word_idx  = ADDR_W'(low_idx / WORD_W);
  assign take      = (state_reg == IDLE) && low_valid;
  assign word_bits = pending_reg[int'(word_idx) * WORD_W +: WORD_W];

  // Only the word being latched is cleared, and only in the IDLE->REQ cycle.
  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_clr
      assign clr_vec[gi*WORD_W +: WORD_W] =
        (take && word_idx == ADDR_W'(gi)) ? word_bits : '0;
    end
  endgenerate

  assign pending_next = (pending_reg & ~clr_vec) | trig_in;
  assign hit_vec      = trig_in & pending_reg & ~clr_vec;
  assign pop_cnt      = CNT_W'(popcount(POP_W'(mask_reg)));

  always_comb begin
    state_next      = state_reg;
    mem_req_out     = 1'b0;
    mem_rd_en_out   = 1'b0;
    mem_wr_en_out   = 1'b0;
    mem_wr_data_out = '0;
    case (state_reg)
      IDLE:  if (low_valid) state_next = REQ;
      REQ: begin
        mem_req_out = 1'b1;
        if (mem_gnt_in) begin
          mem_rd_en_out = 1'b1;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        mem_req_out = 1'b1;
        state_next  = WRITE;
      end
      WRITE: begin
        mem_req_out     = 1'b1;
        mem_wr_en_out   = 1'b1;
        mem_wr_data_out = rd_q_reg ^ mask_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
    mem_addr_out = mem_req_out ? addr_reg : '0;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      addr_reg    <= '0;
      mask_reg    <= '0;
      rd_q_reg    <= '0;
      flips_reg   <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (take) begin
        addr_reg <= word_idx;
        mask_reg <= word_bits;
      end
      if (state_reg == WAIT) rd_q_reg <= mem_rd_data_in;
      if (state_reg == WRITE) flips_reg <= flips_reg + pop_cnt;
      if (|hit_vec) ovf_reg <= 1'b1;
      else if (clr_ovf_in) ovf_reg <= 1'b0;
    end
  end

  assign busy_out  = (state_reg != IDLE) || (|pending_reg);
  assign ovf_out   = ovf_reg;
  assign flips_out = flips_reg;

endmodule

// File: tb/tb_weight_flip_writer.sv
// Directed bench for weight_flip_writer with a 1-cycle-latency RAM model.
module tb_weight_flip_writer;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [255:0] trig_in;
  logic         clr_ovf_in;
  logic         mem_req_out;
  logic         mem_gnt_in;
  logic [2:0]   mem_addr_out;
  logic         mem_rd_en_out;
  logic [31:0]  mem_rd_data_in;
  logic         mem_wr_en_out;
  logic [31:0]  mem_wr_data_out;
  logic         busy_out;
  logic         ovf_out;
  logic [15:0]  flips_out;

  logic [31:0]  ram [0:7];
  logic         pre_en;
  logic [2:0]   pre_addr;
  logic [31:0]  pre_data;
  int           wr_count = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           wc0;
  logic [255:0] v;

  always #5 clk_in = ~clk_in;

  weight_flip_writer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .trig_in        (trig_in),
    .clr_ovf_in     (clr_ovf_in),
    .mem_req_out    (mem_req_out),
    .mem_gnt_in     (mem_gnt_in),
    .mem_addr_out   (mem_addr_out),
    .mem_rd_en_out  (mem_rd_en_out),
    .mem_rd_data_in (mem_rd_data_in),
    .mem_wr_en_out  (mem_wr_en_out),
    .mem_wr_data_out(mem_wr_data_out),
    .busy_out       (busy_out),
    .ovf_out        (ovf_out),
    .flips_out      (flips_out)
  );

  always @(posedge clk_in) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_wr_en_out) begin
      ram[mem_addr_out] <= mem_wr_data_out;
      wr_count <= wr_count + 1;
    end
    if (mem_rd_en_out) mem_rd_data_in <= ram[mem_addr_out];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ram_load(input logic [2:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic pulse(input logic [255:0] t);
    trig_in = t;
    tick();
    trig_in = '0;
  endtask

  task automatic do_reset();
    #2 rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  task automatic wait_wr(input string tag, input logic [2:0] ea, input logic [31:0] ed);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_wr_en_out) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      $display("write %s: addr=%0d data=0x%08h", tag, mem_addr_out, mem_wr_data_out);
      check_eq({tag, "_addr"}, mem_addr_out, ea);
      check_eq({tag, "_data"}, mem_wr_data_out, ed);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1; trig_in = '0; clr_ovf_in = 1'b0; mem_gnt_in = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    for (int i = 0; i < 8; i++) ram_load(3'(i), 32'h0);
    check_eq("rst_req", mem_req_out, 0);
    check_eq("rst_wr_en", mem_wr_en_out, 0);
    check_eq("rst_busy", busy_out, 0);
    check_eq("rst_flips", flips_out, 0);
    check_eq("rst_ovf", ovf_out, 0);
    rst_in = 1'b0;

    // 1: single bit, exact latency
    v = '0; v[5] = 1'b1;
    pulse(v);
    tick();
    check_eq("t1_c2_req", mem_req_out, 1);
    check_eq("t1_c2_rd", mem_rd_en_out, 1);
    tick();
    check_eq("t1_c3_wr", mem_wr_en_out, 0);
    tick();
    $display("write t1: addr=%0d data=0x%08h", mem_addr_out, mem_wr_data_out);
    check_eq("t1_c4_wr", mem_wr_en_out, 1);
    check_eq("t1_c4_data", mem_wr_data_out, 32'h20);
    check_eq("t1_c4_addr", mem_addr_out, 0);
    tick();
    check_eq("t1_busy", busy_out, 0);
    check_eq("t1_flips", flips_out, 1);
    check_eq("t1_ram0", ram[0], 32'h20);

    // 2: two bits in one word, one RMW
    do_reset();
    ram_load(0, 32'hFF);
    wc0 = wr_count;
    v = '0; v[3] = 1'b1; v[7] = 1'b1;
    pulse(v);
    wait_wr("t2", 0, 32'h77);
    repeat (4) tick();
    check_eq("t2_flips", flips_out, 2);
    check_eq("t2_nwr", wr_count - wc0, 1);
    check_eq("t2_busy", busy_out, 0);

    // 3: two words, lowest first
    do_reset();
    ram_load(0, 0); ram_load(1, 0);
    v = '0; v[40] = 1'b1; v[2] = 1'b1;
    pulse(v);
    wait_wr("t3a", 0, 32'h4);
    tick();
    wait_wr("t3b", 1, 32'h100);
    repeat (2) tick();
    check_eq("t3_flips", flips_out, 2);
    check_eq("t3_ram1", ram[1], 32'h100);

    // 4: duplicate trigger while pending -> ovf, dropped
    do_reset();
    ram_load(0, 0);
    mem_gnt_in = 1'b0;
    v = '0; v[0] = 1'b1;
    pulse(v);
    repeat (2) tick();
    v = '0; v[9] = 1'b1;
    pulse(v);
    check_eq("t4_ovf_first", ovf_out, 0);
    pulse(v);
    check_eq("t4_ovf_set", ovf_out, 1);
    check_eq("t4_wr_held", mem_wr_en_out, 0);
    mem_gnt_in = 1'b1;
    wait_wr("t4a", 0, 32'h1);
    tick();
    wait_wr("t4b", 0, 32'h201);
    repeat (2) tick();
    check_eq("t4_flips", flips_out, 2);
    check_eq("t4_ovf_sticky", ovf_out, 1);
    clr_ovf_in = 1'b1; tick(); clr_ovf_in = 1'b0;
    check_eq("t4_ovf_clr", ovf_out, 0);

    // 5: trigger in WAIT of an RMW on the same word
    do_reset();
    ram_load(0, 0);
    v = '0; v[0] = 1'b1;
    pulse(v);
    repeat (2) tick();
    check_eq("t5_wait_req", mem_req_out, 1);
    v = '0; v[1] = 1'b1;
    pulse(v);
    wait_wr("t5a", 0, 32'h1);
    tick();
    wait_wr("t5b", 0, 32'h3);
    repeat (2) tick();
    check_eq("t5_ram0", ram[0], 32'h3);
    check_eq("t5_flips", flips_out, 2);
    check_eq("t5_ovf", ovf_out, 0);

    // 6: async reset during WAIT abandons the RMW
    ram_load(0, 32'h5A);
    wc0 = wr_count;
    v = '0; v[4] = 1'b1;
    pulse(v);
    repeat (2) tick();
    check_eq("t6_wait_req", mem_req_out, 1);
    #2 rst_in = 1'b1;
    #1;
    check_eq("t6_req", mem_req_out, 0);
    check_eq("t6_wr_en", mem_wr_en_out, 0);
    check_eq("t6_wr_data", mem_wr_data_out, 0);
    check_eq("t6_addr", mem_addr_out, 0);
    check_eq("t6_busy", busy_out, 0);
    check_eq("t6_flips", flips_out, 0);
    tick();
    rst_in = 1'b0;
    repeat (6) tick();
    check_eq("t6_ram0", ram[0], 32'h5A);
    check_eq("t6_nwr", wr_count - wc0, 0);
    check_eq("t6_idle", busy_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
